// File: rtl/undertale_pkg.sv
// ---------------------------------------------------------------------------
// undertale_pkg
//
// Shared definitions for the Undertale-style VGA game blocks (collision
// monitor, sprite movers, HUD).
//
//   H_LAST / V_LAST : coordinates of the last visible pixel of a 640x480 frame
//   HP_W            : width of the hit-point datapath
//   state_t         : player life state {ALIVE, INVULN, DEAD}
//   sat_sub         : saturating subtract used for HP damage
// ---------------------------------------------------------------------------
package undertale_pkg;

    localparam int H_LAST = 639;
    localparam int V_LAST = 479;
    localparam int HP_W   = 8;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    // Returns a-b, clamped at zero instead of wrapping.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                input logic [HP_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/frame_strobe.sv
// ---------------------------------------------------------------------------
// frame_strobe
//
// Flags the last visible pixel of the frame. The pixel counters visit
// (H_LAST, V_LAST) exactly once per frame, so this is a one-cycle-per-frame
// strobe. Shared with the sprite movers so every block agrees on when a
// frame ends.
//
// Ports
//   xx        in  10  current pixel x
//   yy        in  10  current pixel y
//   frame_end out 1   high while (xx, yy) is the last visible pixel
// ---------------------------------------------------------------------------
module frame_strobe
    import undertale_pkg::*;
(
    input  logic [9:0] xx,
    input  logic [9:0] yy,
    output logic       frame_end
);

    assign frame_end = (xx == 10'(H_LAST)) && (yy == 10'(V_LAST));

endmodule

// File: rtl/collision_monitor.sv
// ---------------------------------------------------------------------------
// collision_monitor
//
// Sits downstream of the heart and obstacle sprite generators. Any pixel
// where both masks are set inside the visible area is a collision; those are
// accumulated over a frame and acted on once, at the last pixel of the frame.
// A registered hit costs DAMAGE hit points and opens an invulnerability
// window of INVULN_FRAMES frames, during which further collisions are
// ignored and the obstacle sprite is blanked through isCollisionBig.
// Reaching zero HP parks the FSM in DEAD until restart.
//
// Optional feature macro: HIT_FLASH_EN
//   defined   : heart_blank blinks with FLASH_PERIOD frames per phase while
//               invulnerable (starts hidden on entry, forced visible on exit)
//   undefined : heart_blank is tied low and no flash counter exists
//
// Ports
//   Pclk             in  1   pixel clock
//   rst_n            in  1   asynchronous active-low reset
//   xx, yy           in  10  current pixel coordinates
//   aactive          in  1   visible-area flag
//   HeartSpriteOn    in  1   heart mask for the current pixel
//   ObstacleSpriteOn in  1   obstacle mask, pixel-aligned with the heart mask
//   restart          in  1   synchronous restore to HP_MAX / ALIVE
//   isCollisionBig   out 1   high for the whole invulnerability window
//   hit_pulse        out 1   one-cycle pulse when a hit is registered
//   hp               out 8   current hit points
//   game_over        out 1   high while DEAD
//   heart_blank      out 1   request to hide the heart sprite
//   fsm_state        out 2   life-state encoding, for debug and checkers
//
// Handshake: none. Inputs are sampled every Pclk cycle; outputs are
// registered and change on the cycle after the frame_end pixel (or after
// restart).
// ---------------------------------------------------------------------------
module collision_monitor
    import undertale_pkg::*;
#(
    parameter logic [HP_W-1:0] HP_MAX        = 8'd20,
    parameter logic [HP_W-1:0] DAMAGE        = 8'd4,
`ifdef HIT_FLASH_EN
    parameter logic [7:0]      FLASH_PERIOD  = 8'd4,
`endif
    parameter logic [7:0]      INVULN_FRAMES = 8'd60
) (
    input  logic            Pclk,
    input  logic            rst_n,
    input  logic [9:0]      xx,
    input  logic [9:0]      yy,
    input  logic            aactive,
    input  logic            HeartSpriteOn,
    input  logic            ObstacleSpriteOn,
    input  logic            restart,
    output logic            isCollisionBig,
    output logic            hit_pulse,
    output logic [HP_W-1:0] hp,
    output logic            game_over,
    output logic            heart_blank,
    output logic [1:0]      fsm_state
);

    logic            frame_end;
    logic            overlap;
    logic            frame_hit;
    logic            hit_latch;

    state_t          state;
    state_t          state_nxt;
    logic [HP_W-1:0] hp_nxt;
    logic [HP_W-1:0] hp_dmg;
    logic [7:0]      inv_cnt;
    logic [7:0]      inv_cnt_nxt;
    logic            hit_nxt;

    frame_strobe u_frame_strobe (
        .xx        (xx),
        .yy        (yy),
        .frame_end (frame_end)
    );

    // Overlap outside the visible area is blanking-interval garbage.
    assign overlap = aactive & HeartSpriteOn & ObstacleSpriteOn;

    // The frame_end pixel itself may collide; fold it in directly since the
    // latch is being cleared on that same cycle.
    assign frame_hit = hit_latch | overlap;

    assign hp_dmg = sat_sub(hp, DAMAGE);

    // Collision accumulator for the current frame.
    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            hit_latch <= 1'b0;
        end else if (restart || frame_end) begin
            hit_latch <= 1'b0;
        end else if (overlap) begin
            hit_latch <= 1'b1;
        end
    end

    // Life FSM: state register.
    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ALIVE;
            hp        <= HP_MAX;
            inv_cnt   <= '0;
            hit_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            hp        <= hp_nxt;
            inv_cnt   <= inv_cnt_nxt;
            hit_pulse <= hit_nxt;
        end
    end

    // Life FSM: next state and HP datapath. Only the frame_end cycle moves
    // the FSM; restart overrides everything, including a same-cycle hit.
    always_comb begin
        state_nxt   = state;
        hp_nxt      = hp;
        inv_cnt_nxt = inv_cnt;
        hit_nxt     = 1'b0;

        if (restart) begin
            state_nxt   = ALIVE;
            hp_nxt      = HP_MAX;
            inv_cnt_nxt = '0;
        end else if (frame_end) begin
            unique case (state)
                ALIVE: begin
                    if (frame_hit) begin
                        hit_nxt = 1'b1;
                        hp_nxt  = hp_dmg;
                        if (hp_dmg == '0) begin
                            state_nxt = DEAD;
                        end else begin
                            state_nxt   = INVULN;
                            // Counts down through 0, so the window spans
                            // INVULN_FRAMES frame_end cycles.
                            inv_cnt_nxt = INVULN_FRAMES - 8'd1;
                        end
                    end
                end
                INVULN: begin
                    if (inv_cnt == '0) begin
                        state_nxt = ALIVE;
                    end else begin
                        inv_cnt_nxt = inv_cnt - 8'd1;
                    end
                end
                DEAD: begin
                    hp_nxt = '0;
                end
                default: begin
                    state_nxt = ALIVE;
                end
            endcase
        end
    end

    assign isCollisionBig = (state == INVULN);
    assign game_over      = (state == DEAD);
    assign fsm_state      = state;

`ifdef HIT_FLASH_EN
    logic [7:0] flash_cnt;
    logic       blank_q;

    // Blink phase tracker. It restarts on every INVULN entry so each window
    // begins with the heart hidden, and it is cleared on exit so the heart
    // is always visible outside the window.
    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt <= '0;
            blank_q   <= 1'b0;
        end else if (restart) begin
            flash_cnt <= '0;
            blank_q   <= 1'b0;
        end else if (frame_end) begin
            if (state != INVULN && state_nxt == INVULN) begin
                flash_cnt <= '0;
                blank_q   <= 1'b1;
            end else if (state == INVULN && state_nxt != INVULN) begin
                flash_cnt <= '0;
                blank_q   <= 1'b0;
            end else if (state == INVULN) begin
                if (flash_cnt == FLASH_PERIOD - 8'd1) begin
                    flash_cnt <= '0;
                    blank_q   <= ~blank_q;
                end else begin
                    flash_cnt <= flash_cnt + 8'd1;
                end
            end
        end
    end

    assign heart_blank = blank_q;
`else
    assign heart_blank = 1'b0;
`endif

endmodule

// File: tb/tb_collision_monitor.sv
// ---------------------------------------------------------------------------
// tb_collision_monitor
//
// Two instances share one stimulus stream: dut_a with default parameters and
// dut_b with HP_MAX=10, INVULN_FRAMES=3 (HP sequence 10, 6, 2, 0 exercises
// the saturating deduction from 2). Pixel coordinates are driven sparsely: a
// "frame" is a handful of arbitrary in-frame pixels followed by (639,479).
// The reference model tracks, per instance, the HP, how many frame ends of
// invulnerability remain, whether the player is dead, and whether any
// collision has been seen since the last frame end.
// ---------------------------------------------------------------------------
module tb_collision_monitor;

    logic       Pclk;
    logic       rst_n;
    logic [9:0] xx;
    logic [9:0] yy;
    logic       aactive;
    logic       HeartSpriteOn;
    logic       ObstacleSpriteOn;
    logic       restart;

    logic       big_a, pulse_a, go_a, blank_a;
    logic [7:0] hp_a;
    logic [1:0] st_a;
    logic       big_b, pulse_b, go_b, blank_b;
    logic [7:0] hp_b;
    logic [1:0] st_b;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    initial Pclk = 1'b0;
    always #5 Pclk = ~Pclk;

    collision_monitor dut_a (
        .Pclk             (Pclk),
        .rst_n            (rst_n),
        .xx               (xx),
        .yy               (yy),
        .aactive          (aactive),
        .HeartSpriteOn    (HeartSpriteOn),
        .ObstacleSpriteOn (ObstacleSpriteOn),
        .restart          (restart),
        .isCollisionBig   (big_a),
        .hit_pulse        (pulse_a),
        .hp               (hp_a),
        .game_over        (go_a),
        .heart_blank      (blank_a),
        .fsm_state        (st_a)
    );

    collision_monitor #(
        .HP_MAX        (8'd10),
        .DAMAGE        (8'd4),
        .INVULN_FRAMES (8'd3)
    ) dut_b (
        .Pclk             (Pclk),
        .rst_n            (rst_n),
        .xx               (xx),
        .yy               (yy),
        .aactive          (aactive),
        .HeartSpriteOn    (HeartSpriteOn),
        .ObstacleSpriteOn (ObstacleSpriteOn),
        .restart          (restart),
        .isCollisionBig   (big_b),
        .hit_pulse        (pulse_b),
        .hp               (hp_b),
        .game_over        (go_b),
        .heart_blank      (blank_b),
        .fsm_state        (st_b)
    );

    // ---------------- reference model ----------------
    int p_max[2] = '{20, 10};
    int p_inv[2] = '{60, 3};
    localparam int P_DMG   = 4;
    localparam int P_FLASH = 4;

    int m_hp[2];
    int m_inv_left[2];    // frame ends still to pass before ALIVE again
    int m_since[2];       // frame ends seen since entering invulnerability
    bit m_dead[2];
    bit m_seen[2];        // collision seen since the last frame end
    bit m_pulse[2];

    task automatic model_init();
        for (int i = 0; i < 2; i++) begin
            m_hp[i]       = p_max[i];
            m_inv_left[i] = 0;
            m_since[i]    = 0;
            m_dead[i]     = 1'b0;
            m_seen[i]     = 1'b0;
            m_pulse[i]    = 1'b0;
        end
    endtask

    task automatic model_step(input int x, input int y, input bit act,
                              input bit h, input bit o, input bit rs);
        bit hit_now;
        bit last_px;
        hit_now = act && h && o;
        last_px = (x == 639) && (y == 479);
        for (int i = 0; i < 2; i++) begin
            m_pulse[i] = 1'b0;
            if (rs) begin
                model_init_one(i);
            end else if (last_px) begin
                if (m_dead[i]) begin
                    m_hp[i] = 0;
                end else if (m_inv_left[i] > 0) begin
                    m_inv_left[i] = m_inv_left[i] - 1;
                    m_since[i]    = m_since[i] + 1;
                end else if (m_seen[i] || hit_now) begin
                    m_pulse[i] = 1'b1;
                    m_hp[i]    = (m_hp[i] > P_DMG) ? m_hp[i] - P_DMG : 0;
                    if (m_hp[i] == 0) begin
                        m_dead[i] = 1'b1;
                    end else begin
                        m_inv_left[i] = p_inv[i];
                        m_since[i]    = 0;
                    end
                end
                m_seen[i] = 1'b0;
            end else if (hit_now) begin
                m_seen[i] = 1'b1;
            end
        end
    endtask

    task automatic model_init_one(input int i);
        m_hp[i]       = p_max[i];
        m_inv_left[i] = 0;
        m_since[i]    = 0;
        m_dead[i]     = 1'b0;
        m_seen[i]     = 1'b0;
        m_pulse[i]    = 1'b0;
    endtask

    // {hp, hit_pulse, isCollisionBig, game_over, heart_blank, state}
    function automatic logic [13:0] expv(input int i);
        logic [1:0] st;
        logic       blank;
        st = m_dead[i] ? 2'd2 : ((m_inv_left[i] > 0) ? 2'd1 : 2'd0);
`ifdef HIT_FLASH_EN
        blank = (m_inv_left[i] > 0) && (((m_since[i] / P_FLASH) % 2) == 0);
`else
        blank = 1'b0;
`endif
        return {8'(m_hp[i]), m_pulse[i], (m_inv_left[i] > 0), m_dead[i], blank, st};
    endfunction

    function automatic logic [13:0] obs(input int i);
        if (i == 0) return {hp_a, pulse_a, big_a, go_a, blank_a, st_a};
        return {hp_b, pulse_b, big_b, go_b, blank_b, st_b};
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_pix(input int x, input int y, input bit act,
                             input bit h, input bit o, input bit rs);
        xx               = 10'(x);
        yy               = 10'(y);
        aactive          = act;
        HeartSpriteOn    = h;
        ObstacleSpriteOn = o;
        restart          = rs;
        @(posedge Pclk);
        model_step(x, y, act, h, o, rs);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_init();
        #4;
        rst_n = 1'b1;
    endtask

    // Four arbitrary pixels (first one at (300,300) colliding if body_hit),
    // then the frame-end pixel.
    task automatic run_frame(input bit body_hit, input bit end_hit, input bit end_act,
                             input bit end_rs, input bit body_rs);
        for (int k = 0; k < 4; k++) begin
            int x, y;
            bit h, o, act;
            if (k == 0 && body_hit) begin
                x = 300; y = 300; h = 1'b1; o = 1'b1; act = 1'b1;
            end else begin
                x   = $urandom_range(0, 638);
                y   = $urandom_range(0, 479);
                act = 1'($urandom_range(0, 1));
                h   = 1'($urandom_range(0, 1));
                // Both masks only when outside the visible area.
                o   = act ? (h ? 1'b0 : 1'($urandom_range(0, 1))) : 1'($urandom_range(0, 1));
            end
            drive_pix(x, y, act, h, o, body_rs && (k == 2));
        end
        drive_pix(639, 479, end_act, end_hit, end_hit, end_rs);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Pclk = Pclk;
        rst_n = 1'b0; xx = '0; yy = '0; aactive = 1'b0;
        HeartSpriteOn = 1'b0; ObstacleSpriteOn = 1'b0; restart = 1'b0;
        model_init();
        #12;
        checks++;
        if ({hp_a, pulse_a, big_a, go_a, blank_a, st_a} !== {8'd20, 6'd0}) begin
            failures++;
            $display("FAIL reset_a got=%h exp=%h", {hp_a, pulse_a, big_a, go_a, blank_a, st_a}, {8'd20, 6'd0});
        end
        checks++;
        if (hp_b !== 8'd10) begin
            failures++;
            $display("FAIL reset_b_hp got=%0d exp=10", hp_b);
        end
        rst_n = 1'b1;
        @(posedge Pclk); #1;
    endtask

    task automatic test_single_hit();
        run_frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (hp_a !== 8'd16 || pulse_a !== 1'b1 || big_a !== 1'b1) begin
            failures++;
            $display("FAIL single_hit got hp=%0d pulse=%b big=%b exp hp=16 pulse=1 big=1", hp_a, pulse_a, big_a);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
                failures++;
                $display("FAIL single_hit_model dut%0d got=%h exp=%h", i, obs(i), expv(i));
            end
        end
        drive_pix(10, 10, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pulse_a !== 1'b0 || hp_a !== 8'd16) begin
            failures++;
            $display("FAIL pulse_width got pulse=%b hp=%0d exp pulse=0 hp=16", pulse_a, hp_a);
        end
    endtask

    task automatic test_invuln();
        for (int f = 0; f < 60; f++) begin
            run_frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL invuln dut%0d frame=%0d got=%h exp=%h", i, f, obs(i), expv(i));
                end
            end
        end
        checks++;
        if (hp_a !== 8'd16 || big_a !== 1'b0) begin
            failures++;
            $display("FAIL invuln_end got hp=%0d big=%b exp hp=16 big=0", hp_a, big_a);
        end
        run_frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (hp_a !== 8'd12 || pulse_a !== 1'b1) begin
            failures++;
            $display("FAIL after_invuln got hp=%0d pulse=%b exp hp=12 pulse=1", hp_a, pulse_a);
        end
    endtask

    task automatic test_five_hits();
        run_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // restart
        for (int k = 1; k <= 5; k++) begin
            run_frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL five_hits dut%0d hit=%0d got=%h exp=%h", i, k, obs(i), expv(i));
                end
            end
            if (k == 3) begin
                checks++;
                if (hp_b !== 8'd0 || go_b !== 1'b1) begin
                    failures++;
                    $display("FAIL saturate got hp=%0d game_over=%b exp hp=0 game_over=1", hp_b, go_b);
                end
            end
            if (k < 5) begin
                for (int f = 0; f < 60; f++) run_frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            end
        end
        checks++;
        if (hp_a !== 8'd0 || go_a !== 1'b1) begin
            failures++;
            $display("FAIL fifth_hit got hp=%0d game_over=%b exp hp=0 game_over=1", hp_a, go_a);
        end
        for (int f = 0; f < 3; f++) begin
            run_frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if (hp_a !== 8'd0 || pulse_a !== 1'b0 || go_a !== 1'b1) begin
                failures++;
                $display("FAIL dead_hold frame=%0d got hp=%0d pulse=%b go=%b exp 0 0 1", f, hp_a, pulse_a, go_a);
            end
        end
    endtask

    task automatic test_last_pixel();
        run_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // restart
        run_frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (hp_a !== 8'd16 || pulse_a !== 1'b1) begin
            failures++;
            $display("FAIL last_pixel_active got hp=%0d pulse=%b exp hp=16 pulse=1", hp_a, pulse_a);
        end
        run_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // restart
        run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (hp_a !== 8'd20 || pulse_a !== 1'b0 || big_a !== 1'b0) begin
            failures++;
            $display("FAIL last_pixel_inactive got hp=%0d pulse=%b big=%b exp 20 0 0", hp_a, pulse_a, big_a);
        end
    endtask

    task automatic test_restart_collide();
        bit pat[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        run_frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // take damage first
        run_frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);   // restart on a hit frame end
        checks++;
        if (hp_a !== 8'd20 || st_a !== 2'd0 || pulse_a !== 1'b0 || big_a !== 1'b0) begin
            failures++;
            $display("FAIL restart_collide got hp=%0d st=%0d pulse=%b big=%b exp 20 0 0 0",
                     hp_a, st_a, pulse_a, big_a);
        end
        run_frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);   // enter invulnerability
        for (int f = 0; f < 8; f++) begin
            if (f > 0) run_frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
`ifdef HIT_FLASH_EN
            if (blank_a !== pat[f]) begin
                failures++;
                $display("FAIL flash frame=%0d got=%b exp=%b", f, blank_a, pat[f]);
            end
`else
            if (blank_a !== 1'b0 || pat[f] === 1'bx) begin
                failures++;
                $display("FAIL flash_off frame=%0d got=%b exp=0", f, blank_a);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        run_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // restart
        drive_pix(100, 100, 1'b1, 1'b1, 1'b1, 1'b0);
        do_reset();
        checks++;
        if (hp_a !== 8'd20 || st_a !== 2'd0) begin
            failures++;
            $display("FAIL async_reset got hp=%0d st=%0d exp 20 0", hp_a, st_a);
        end
        drive_pix(639, 479, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (hp_a !== 8'd20 || pulse_a !== 1'b0) begin
            failures++;
            $display("FAIL latch_discard got hp=%0d pulse=%b exp 20 0", hp_a, pulse_a);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 200; f++) begin
            run_frame($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                      $urandom_range(0, 29) == 0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL random dut%0d frame=%0d got=%h exp=%h", i, f, obs(i), expv(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_invuln();
        test_five_hits();
        test_last_pixel();
        test_restart_collide();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
